// File: rtl/game_pkg.sv
// Shared encodings for the game sequencer: FSM states, wrapper status codes
// and button indices.
package game_pkg;

    typedef enum logic [2:0] {
        ST_START     = 3'b000,
        ST_PLAYING   = 3'b001,
        ST_PAUSED    = 3'b010,
        ST_GAME_OVER = 3'b011
    } game_state_e;

    localparam logic [2:0] GS_RUNNING = 3'b000;
    localparam logic [2:0] GS_LOST    = 3'b001;
    localparam logic [2:0] GS_CLEARED = 3'b010;

    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_d;
    logic [19:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // cnt counts consecutive synchronized samples that disagree with level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: start / playing / paused / game-over flow, the game-over
// hold timer and the high-score register.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter logic [19:0]      DEBOUNCE_CYCLES  = 20'd270000,
    parameter int               CNT_W            = 28,
    parameter logic [CNT_W-1:0] OVER_HOLD_CYCLES = 28'd81000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  buttons,
    input  logic [2:0]  game_status,
    input  logic [13:0] score,
    output logic [2:0]  game_state,
    output logic [13:0] high_score,
    output logic        player_won
);

    localparam logic [CNT_W-1:0] ONE       = 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = OVER_HOLD_CYCLES - ONE;

    logic             start_p;
    logic             pause_p;
    game_state_e      state_q;
    game_state_e      state_d;
    logic [CNT_W-1:0] hold_q;
    logic             won_q;
    logic [13:0]      hs_q;
    logic             unused_buttons;

    assign unused_buttons = ^buttons[4:2];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (buttons[BTN_START]),
        .press (start_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (buttons[BTN_PAUSE]),
        .press (pause_p)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:     if (start_p) state_d = ST_PLAYING;
            // status codes outrank a coincident pause press
            ST_PLAYING: begin
                if (game_status == GS_LOST || game_status == GS_CLEARED) state_d = ST_GAME_OVER;
                else if (pause_p)                                         state_d = ST_PAUSED;
            end
            ST_PAUSED:    if (pause_p || start_p) state_d = ST_PLAYING;
            ST_GAME_OVER: if (start_p || hold_q == HOLD_LAST) state_d = ST_START;
            default:      state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_START;
            hold_q  <= '0;
            won_q   <= 1'b0;
            hs_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_q == ST_GAME_OVER && state_d == ST_GAME_OVER) ? hold_q + ONE : '0;
            if (state_d == ST_GAME_OVER && state_q != ST_GAME_OVER) won_q <= (game_status == GS_CLEARED);
            else if (state_d != ST_GAME_OVER)                       won_q <= 1'b0;
            // score lags the wrapper by a cycle, so keep sampling for the whole game-over period
            if (state_q == ST_GAME_OVER && score > hs_q) hs_q <= score;
        end
    end

    assign game_state = state_q;
    assign high_score = hs_q;
    assign player_won = won_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the game rules.
module tb_game_state_ctrl;

    localparam int D  = 4;
    localparam int OH = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  buttons = '0;
    logic [2:0]  game_status = '0;
    logic [13:0] score = '0;
    logic [2:0]  game_state;
    logic [13:0] high_score;
    logic        player_won;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .DEBOUNCE_CYCLES  (20'd4),
        .CNT_W            (28),
        .OVER_HOLD_CYCLES (28'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buttons     (buttons),
        .game_status (game_status),
        .score       (score),
        .game_state  (game_state),
        .high_score  (high_score),
        .player_won  (player_won)
    );

    // Model: hist[b][i] is the raw level sampled i edges ago; a level is
    // accepted once the D oldest synchronized samples agree, and the press
    // reaches the sequencer two edges after acceptance.
    int hist [2][D+2];
    int acc  [2];
    int rh0  [2];
    int rh1  [2];
    int m_state, m_hs, m_won, m_hold;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < D + 2; i++) hist[b][i] = 0;
            acc[b] = 0;
            rh0[b] = 0;
            rh1[b] = 0;
        end
        m_state = 0;
        m_hs    = 0;
        m_won   = 0;
        m_hold  = 0;
    endfunction

    function automatic int debounce_step(int b, int raw);
        int  pulse;
        int  rose;
        bit  same;
        pulse = rh1[b];
        rose  = 0;
        same  = 1'b1;
        for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw;
        for (int i = 3; i <= D + 1; i++) if (hist[b][i] != hist[b][2]) same = 1'b0;
        if (same && hist[b][2] != acc[b]) begin
            acc[b] = hist[b][2];
            rose   = acc[b];
        end
        rh1[b] = rh0[b];
        rh0[b] = rose;
        return pulse;
    endfunction

    function automatic void model_step();
        int sp, pp, st, sc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sp = debounce_step(0, int'(buttons[0]));
        pp = debounce_step(1, int'(buttons[1]));
        st = int'(game_status);
        sc = int'(score);
        case (m_state)
            0: if (sp != 0) m_state = 1;
            1: begin
                if (st == 1)       begin m_state = 3; m_won = 0; end
                else if (st == 2)  begin m_state = 3; m_won = 1; end
                else if (pp != 0)  m_state = 2;
            end
            2: if (pp != 0 || sp != 0) m_state = 1;
            default: begin
                if (sc > m_hs) m_hs = sc;
                if (sp != 0 || m_hold == OH - 1) begin
                    m_state = 0;
                    m_hold  = 0;
                    m_won   = 0;
                end else begin
                    m_hold++;
                end
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_state", {13'd0, game_state}, m_state[15:0]);
        check("model_high_score", {2'd0, high_score}, m_hs[15:0]);
        check("model_player_won", {15'd0, player_won}, m_won[15:0]);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b);
        buttons[b] = 1'b1;
        ticks(6);
        buttons[b] = 1'b0;
        ticks(8);
    endtask

    initial begin
        model_reset();
        ticks(2);
        check("reset_state", {13'd0, game_state}, 16'd0);
        check("reset_high_score", {2'd0, high_score}, 16'd0);
        check("reset_player_won", {15'd0, player_won}, 16'd0);
        rst_n = 1'b1;
        ticks(2);

        buttons[0] = 1'b1;
        ticks(2);
        buttons[0] = 1'b0;
        ticks(12);
        check("glitch_ignored", {13'd0, game_state}, 16'd0);

        buttons[0] = 1'b1;
        ticks(D + 3);
        check("start_latency_early", {13'd0, game_state}, 16'd0);
        ticks(1);
        check("start_latency_exact", {13'd0, game_state}, 16'd1);
        ticks(2);
        buttons[0] = 1'b0;
        ticks(8);

        score = 14'd120;
        game_status = 3'b001;
        ticks(1);
        check("lost_state", {13'd0, game_state}, 16'd3);
        check("lost_won", {15'd0, player_won}, 16'd0);
        game_status = 3'b000;
        ticks(1);
        check("lost_high_score", {2'd0, high_score}, 16'd120);
        ticks(OH - 2);
        check("hold_not_expired", {13'd0, game_state}, 16'd3);
        ticks(1);
        check("hold_expired", {13'd0, game_state}, 16'd0);
        check("hold_high_score", {2'd0, high_score}, 16'd120);

        press(0);
        check("second_game", {13'd0, game_state}, 16'd1);
        score = 14'd80;
        game_status = 3'b010;
        ticks(1);
        check("cleared_state", {13'd0, game_state}, 16'd3);
        check("cleared_won", {15'd0, player_won}, 16'd1);
        game_status = 3'b000;
        ticks(1);
        check("lower_score_kept", {2'd0, high_score}, 16'd120);
        press(0);
        check("start_exits_over", {13'd0, game_state}, 16'd0);
        check("won_cleared_on_exit", {15'd0, player_won}, 16'd0);

        press(0);
        check("third_game", {13'd0, game_state}, 16'd1);
        press(1);
        check("paused", {13'd0, game_state}, 16'd2);
        game_status = 3'b001;
        ticks(3);
        check("paused_ignores_status", {13'd0, game_state}, 16'd2);
        game_status = 3'b000;
        press(1);
        check("resumed", {13'd0, game_state}, 16'd1);

        buttons[1] = 1'b1;
        ticks(D + 3);
        game_status = 3'b001;
        ticks(1);
        check("status_beats_pause", {13'd0, game_state}, 16'd3);
        game_status = 3'b000;
        buttons[1] = 1'b0;
        ticks(8);
        check("still_over", {13'd0, game_state}, 16'd3);
        check("hs_before_reset", {2'd0, high_score}, 16'd120);
        rst_n = 1'b0;
        ticks(1);
        check("midgame_reset_state", {13'd0, game_state}, 16'd0);
        check("midgame_reset_hs", {2'd0, high_score}, 16'd0);
        check("midgame_reset_won", {15'd0, player_won}, 16'd0);
        rst_n = 1'b1;
        ticks(2);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) buttons[0] = ~buttons[0];
            if ($urandom_range(0, 7) == 0) buttons[1] = ~buttons[1];
            buttons[4:2] = 3'($urandom);
            case ($urandom_range(0, 31))
                0:       game_status = 3'b001;
                1:       game_status = 3'b010;
                2:       game_status = 3'($urandom_range(3, 7));
                default: game_status = 3'b000;
            endcase
            if ($urandom_range(0, 15) == 0) score = 14'($urandom);
            rst_n = ($urandom_range(0, 799) != 0);
            ticks(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
